// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss-path refill controller streaming one generated block per request.
// Define REFILL_CRITICAL_WORD_FIRST_EN to start each burst at the missed word and wrap within the block.
module cache_refill_ctrl #(
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_addr,
    output logic [31:0] resp_data,
    output logic        resp_last,
    output logic        busy,
    output logic [15:0] refill_count
);
    localparam int OFF = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t           state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [OFF-1:0]   start_q, start_d;
    logic [OFF-1:0]   k_q, k_d;
    logic [OFF-1:0]   idx;
    logic [7:0]       cnt_q, cnt_d;
    logic [15:0]      count_q, count_d;
    logic             unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            start_q <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            start_q <= start_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        start_d = start_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = WAIT;
                base_d  = {req_addr[31:OFF+2], {(OFF+2){1'b0}}};
                start_d = req_addr[OFF+1:2];
                cnt_d   = 8'(LATENCY - 1);
            end
            WAIT: if (cnt_q == 8'd0) begin
                state_d = BURST;
                k_d     = '0;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            BURST: if (resp_ready) begin
                k_d = k_q + 1'b1;
                if (&k_q) begin
                    state_d = IDLE;
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    assign idx         = start_q + k_q;
    assign unused_bits = ^req_addr[1:0];
`else
    assign idx         = k_q;
    assign unused_bits = ^{req_addr[1:0], start_q};
`endif

    // rst gates req_ready so every output reads 0 while reset is held
    assign req_ready    = rst && (state_q == IDLE);
    assign busy         = state_q != IDLE;
    assign resp_valid   = state_q == BURST;
    assign resp_addr    = resp_valid ? (base_q | {{(30-OFF){1'b0}}, idx, 2'b00}) : 32'd0;
    assign resp_data    = {2'b00, resp_addr[31:2]};
    assign resp_last    = resp_valid && (&k_q);
    assign refill_count = count_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: scoreboard bench for cache_refill_ctrl; expected beats are queued at issue time.
// Honours REFILL_CRITICAL_WORD_FIRST_EN to select the expected beat order.
module tb_cache_refill_ctrl;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic        req_ready, resp_valid, resp_last, busy;
    logic [31:0] resp_addr, resp_data;
    logic [15:0] refill_count;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t sb[$];
    int    acc[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_addr(resp_addr), .resp_data(resp_data), .resp_last(resp_last),
        .busy(busy), .refill_count(refill_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expected beat per observed handshake
    always @(negedge clk) begin
        if (rst && req_valid && req_ready) acc.push_back(cyc);
        if (rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got addr 0x%08h expected no beat", resp_addr);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_addr", resp_addr, e.a);
                chk("beat_data", resp_data, e.d);
                chk("beat_last", 32'(resp_last), 32'(e.l));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_block(logic [31:0] addr, int n);
        logic [31:0] base, a;
        int f;
        base = addr & ~32'hF;
        f = CWF ? int'(addr[3:2]) : 0;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * ((f + i) % 4));
            sb.push_back({a, a >> 2, i == 3});
        end
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_req_ready"}, 32'(req_ready), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_resp_valid"}, 32'(resp_valid), 0);
        chk({nm, "_resp_addr"}, resp_addr, 0);
        chk({nm, "_resp_data"}, resp_data, 0);
        chk({nm, "_resp_last"}, 32'(resp_last), 0);
        chk({nm, "_count"}, 32'(refill_count), 0);
    endtask

    task automatic wait_idle(string nm);
        int c;
        c = 0;
        while (!req_ready && c < 50) begin
            tick();
            c++;
        end
        chk({nm, "_done"}, 32'(req_ready), 1);
    endtask

    task automatic do_refill(string nm, logic [31:0] addr, logic [31:0] first_a, int stall, logic [15:0] cnt_exp);
        logic [31:0] b1;
        b1 = (addr & ~32'hF) | ((first_a + 32'd4) & 32'hF);
        push_block(addr, 4);
        resp_ready = 1'b1;
        req_addr = addr;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({nm, "_busy"}, 32'(busy), 1);
        chk({nm, "_req_ready_busy"}, 32'(req_ready), 0);
        chk({nm, "_lat0"}, 32'(resp_valid), 0);
        tick();
        chk({nm, "_lat1"}, 32'(resp_valid), 0);
        tick();
        chk({nm, "_lat2"}, 32'(resp_valid), 0);
        tick();
        chk({nm, "_first_valid"}, 32'(resp_valid), 1);
        chk({nm, "_first_addr"}, resp_addr, first_a);
        chk({nm, "_first_data"}, resp_data, first_a >> 2);
        if (stall > 0) begin
            tick();
            resp_ready = 1'b0;
            for (int s = 0; s <= stall; s++) begin
                chk({nm, "_hold_valid"}, 32'(resp_valid), 1);
                chk({nm, "_hold_addr"}, resp_addr, b1);
                chk({nm, "_hold_data"}, resp_data, b1 >> 2);
                chk({nm, "_hold_last"}, 32'(resp_last), 0);
                if (s < stall) tick();
            end
            resp_ready = 1'b1;
        end
        wait_idle(nm);
        chk({nm, "_count"}, 32'(refill_count), 32'(cnt_exp));
        chk({nm, "_sb_empty"}, 32'(sb.size()), 0);
    endtask

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready), 1);
        chk("rel_busy", 32'(busy), 0);
        chk("rel_count", 32'(refill_count), 0);

        do_refill("basic", 32'h40, 32'h40, 0, 16'd1);
        do_refill("cwf", 32'h48, CWF ? 32'h48 : 32'h40, 0, 16'd2);
        do_refill("bp", 32'h0, 32'h0, 2, 16'd3);

        push_block(32'h0, 2);
        req_addr = 32'h0;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk_zero("mid_rst");
        chk("mid_rst_sb_empty", 32'(sb.size()), 0);
        tick();
        rst = 1'b1;
        tick();
        do_refill("post_rst", 32'h4, CWF ? 32'h4 : 32'h0, 0, 16'd1);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        acc.delete();
        push_block(32'h0, 4);
        push_block(32'h0, 4);
        req_addr = 32'h0;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        c = 0;
        while (refill_count != 16'd2 && c < 60) begin
            tick();
            c++;
        end
        req_valid = 1'b0;
        chk("b2b_count", 32'(refill_count), 2);
        chk("b2b_accepts", 32'(acc.size()), 2);
        if (acc.size() == 2) chk("b2b_spacing", 32'(acc[1] - acc[0]), 8);
        chk("b2b_sb_empty", 32'(sb.size()), 0);
        tick();
        tick();
        chk("b2b_no_extra", 32'(acc.size()), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-path refill controller that sits directly downstream of the 2-way set-associative cache. On a cache miss it accepts one block-aligned refill request, models main-memory access latency, then streams the block back one word per beat under a valid/ready handshake. Backing-memory contents are generated, not stored: every word's data equals its word index (byte address >> 2). This makes the refill data match the cache's expected miss data, e.g. byte address 0x40 returns 0x10.

## Interface
- BLOCK_WORDS, 4: words per cache block; power of two, 2..16.
- LATENCY, 3: number of cycles from request acceptance to the first response beat; 1..255 (0 is illegal).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- req_valid  in  1  refill request present.
- req_ready  out  1  controller can accept a request.
- req_addr  in  32  miss byte address; bits [1:0] ignored.
- resp_valid  out  1  response beat present.
- resp_ready  in  1  cache accepts the current beat.
- resp_addr  out  32  byte address of the current beat.
- resp_data  out  32  data of the current beat, equal to resp_addr >> 2.
- resp_last  out  1  marks the final beat of the block.
- busy  out  1  a refill is in progress.
- refill_count  out  16  number of completed refills; wraps at 0xFFFF -> 0.

## Operation
- FSM states: IDLE, WAIT, BURST.
- Reset (rst=0): state goes to IDLE asynchronously. While rst=0, every output is 0, including req_ready; refill_count=0 and the internal counters clear.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch base = req_addr & ~(4*BLOCK_WORDS-1) and start word = req_addr[log2(4*BLOCK_WORDS)-1:2]; load the latency counter; go to WAIT.
- WAIT:
  - busy=1; the counter decrements each cycle.
  - When it expires, go to BURST with beat index k=0.
- BURST:
  - resp_valid=1.
  - resp_addr = base + 4*((first + k) mod BLOCK_WORDS).
  - resp_last = (k == BLOCK_WORDS-1).
  - A beat completes only on resp_valid & resp_ready. k then increments.
  - On the last beat's handshake: refill_count increments and the state returns to IDLE.
- Backpressure: while resp_ready=0, resp_addr, resp_data and resp_last hold stable.
- req_valid outside IDLE is ignored. It is not queued; the requester must hold it until req_ready.
- Reset mid-operation aborts the refill with no partial count. The next request restarts cleanly.

## Timing
- Request accepted at rising edge E: busy=1 from E. The first resp_valid=1 appears after edge E+LATENCY.
- One beat per cycle when resp_ready=1 continuously. The full refill occupies LATENCY+BLOCK_WORDS cycles.
- After the last-beat handshake at edge F, the state is IDLE and req_ready=1 from F. A new request can be accepted at edge F+1.
- busy = (state != IDLE). resp_* outputs are registered or decoded from registered state only; there is no combinational path from req_* to resp_*.
- refill_count updates at the same edge as the last handshake.

## Configuration
- REFILL_CRITICAL_WORD_FIRST_EN defined: first = the latched start word, so the burst begins at the missed word and wraps within the block.
- Not defined: first = 0, so the burst always runs from the block base upward and the start word is ignored.
- Timing, handshake and beat count are identical in both builds.

## Test plan
- Reset: hold rst=0 with clk running -> all outputs 0. Release -> req_ready=1, busy=0, refill_count=0.
- Basic refill, macro off, req_addr=0x40, resp_ready=1:
  - Accepted at E; first beat after E+3.
  - Beats (addr/data): 0x40/0x10, 0x44/0x11, 0x48/0x12, 0x4C/0x13, with resp_last on beat 4.
  - refill_count=1; req_ready=1 afterwards.
- Critical word first, macro on, req_addr=0x48 -> beats 0x48/0x12, 0x4C/0x13, 0x40/0x10, 0x44/0x11, last on 0x44. Same stimulus with macro off -> order starts at 0x40.
- Backpressure: during refill of 0x0, drop resp_ready for 2 cycles on beat 2 -> resp_valid=1 with 0x4/0x1 held stable. Completes with 4 handshakes total; refill_count +1.
- Reset mid-burst: assert rst=0 after beat 2 -> outputs go to 0 immediately and refill_count=0. After release, req_addr=0x4 -> beats 0x0..0xC with data 0..3 (macro off); refill_count=1.
- Ignore while busy: keep req_valid=1 with req_addr=0x0 continuously -> requests accepted only in IDLE. Back-to-back refills are spaced LATENCY+BLOCK_WORDS+1 = 8 cycles apart; refill_count reads 2 after two bursts.
